// File: rtl/nmi_pkg.sv
// Shared NMI definitions: field widths, error read data, arbiter FSM states and request payload.
package nmi_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    ERR
  } state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
  } nmi_req_t;

endpackage

// File: rtl/nmi_arbmux_if.sv
// NMI master/slave bundle around nmi_arbmux; master and slave modports give the
// requester and target views, mux is the arbiter's own view.
interface nmi_arbmux_if #(
  parameter int unsigned NMSTR = 2,
  parameter int unsigned NSLV  = 3
);
  import nmi_pkg::*;

  logic [NMSTR-1:0]             m_valid_i;
  logic [NMSTR-1:0][ADDR_W-1:0] m_addr_i;
  logic [NMSTR-1:0][DATA_W-1:0] m_wdata_i;
  logic [NMSTR-1:0][STRB_W-1:0] m_wstrb_i;
  logic [NMSTR-1:0]             m_ready_o;
  logic [NMSTR-1:0][DATA_W-1:0] m_rdata_o;

  logic [NSLV-1:0]              s_valid_o;
  logic [ADDR_W-1:0]            s_addr_o;
  logic [DATA_W-1:0]            s_wdata_o;
  logic [STRB_W-1:0]            s_wstrb_o;
  logic [NSLV-1:0]              s_ready_i;
  logic [NSLV-1:0][DATA_W-1:0]  s_rdata_i;

  modport master (
    output m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i,
    input  m_ready_o, m_rdata_o
  );

  modport slave (
    input  s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o,
    output s_ready_i, s_rdata_i
  );

  modport mux (
    input  m_valid_i, m_addr_i, m_wdata_i, m_wstrb_i, s_ready_i, s_rdata_i,
    output m_ready_o, m_rdata_o, s_valid_o, s_addr_o, s_wdata_o, s_wstrb_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester
// found searching upward from the index after last, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter  int unsigned N  = 2,
  localparam int unsigned LW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [N-1:0]  gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int unsigned off = 1; off <= N; off++) begin
      if (!found && req[LW'((32'(last) + off) % N)]) begin
        gnt[LW'((32'(last) + off) % N)] = 1'b1;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nmi_arbmux.sv
// NMI N-master to M-slave arbitrating mux. Slave i owns addr[31:24] == SLV_BASE[i]
// (slice 0 is the LSB byte). Optional BUSY timeout: define NMI_ARBMUX_TIMEOUT_EN.
module nmi_arbmux
  import nmi_pkg::*;
#(
  parameter int unsigned            NMSTR     = 2,
  parameter int unsigned            NSLV      = 3,
  parameter logic [NSLV-1:0][7:0]   SLV_BASE  = {8'h10, 8'h30, 8'h03},
  parameter logic [DATA_W-1:0]      ERR_RDATA = ERR_RDATA_DEF
`ifdef NMI_ARBMUX_TIMEOUT_EN
  , parameter int unsigned          TIMEOUT_CYC = 1024
`endif
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  nmi_arbmux_if.mux        bus,
  output logic [NMSTR-1:0] gnt_o,
  output logic             err_o
);

  localparam int unsigned MW = $clog2(NMSTR);
  localparam int unsigned SW = (NSLV > 1) ? $clog2(NSLV) : 1;

  state_e            state_q;
  logic [NMSTR-1:0]  gnt_q;
  logic [MW-1:0]     last_q;
  logic [MW-1:0]     gidx_q;
  logic [SW-1:0]     sel_q;

  logic [NMSTR-1:0]  arb_gnt;
  logic [MW-1:0]     arb_idx;
  logic [7:0]        arb_hi;
  logic [SW-1:0]     dec_idx;
  logic [4:0]        nmatch;
  logic              dec_hit;
  nmi_req_t          greq;

  rr_arbiter #(.N(NMSTR)) u_arb (
    .req  (bus.m_valid_i),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  // Encode the winner and decode its address; only a unique match is a hit.
  always_comb begin
    arb_idx = '0;
    for (int unsigned i = 0; i < NMSTR; i++) begin
      if (arb_gnt[i]) arb_idx = MW'(i);
    end
    arb_hi  = bus.m_addr_i[arb_idx][ADDR_W-1 -: 8];
    dec_idx = '0;
    nmatch  = '0;
    for (int unsigned j = 0; j < NSLV; j++) begin
      if (SLV_BASE[j] == arb_hi) begin
        dec_idx = SW'(j);
        nmatch  = nmatch + 5'd1;
      end
    end
    dec_hit = (nmatch == 5'd1);
  end

  always_comb begin
    greq = '{addr:  bus.m_addr_i[gidx_q],
             wdata: bus.m_wdata_i[gidx_q],
             wstrb: bus.m_wstrb_i[gidx_q]};
  end

`ifdef NMI_ARBMUX_TIMEOUT_EN
  logic [15:0] tmo_q;
  logic        tmo_hit;
  assign tmo_hit = (tmo_q == 16'(TIMEOUT_CYC - 1));
`endif

  // Response path is combinational from the selected slave; everything idles at 0.
  always_comb begin
    bus.s_valid_o = '0;
    bus.s_addr_o  = '0;
    bus.s_wdata_o = '0;
    bus.s_wstrb_o = '0;
    bus.m_ready_o = '0;
    bus.m_rdata_o = '0;
    unique case (state_q)
      BUSY: begin
        bus.s_valid_o[sel_q]  = 1'b1;
        bus.s_addr_o          = greq.addr;
        bus.s_wdata_o         = greq.wdata;
        bus.s_wstrb_o         = greq.wstrb;
        bus.m_ready_o[gidx_q] = bus.s_ready_i[sel_q];
        bus.m_rdata_o[gidx_q] = bus.s_rdata_i[sel_q];
      end
      ERR: begin
        bus.m_ready_o[gidx_q] = 1'b1;
        bus.m_rdata_o[gidx_q] = ERR_RDATA;
      end
      default: ;
    endcase
  end

  assign gnt_o = gnt_q;
  assign err_o = (state_q == ERR);

  // Errored masters also advance last_q so a bad requester cannot hog the grant.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= MW'(NMSTR - 1);
      gidx_q  <= '0;
      sel_q   <= '0;
`ifdef NMI_ARBMUX_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (|bus.m_valid_i) begin
            gnt_q   <= arb_gnt;
            gidx_q  <= arb_idx;
            sel_q   <= dec_idx;
            state_q <= dec_hit ? BUSY : ERR;
`ifdef NMI_ARBMUX_TIMEOUT_EN
            tmo_q   <= '0;
`endif
          end
        end
        BUSY: begin
          if (bus.s_ready_i[sel_q]) begin
            last_q  <= gidx_q;
            gnt_q   <= '0;
            state_q <= IDLE;
          end
`ifdef NMI_ARBMUX_TIMEOUT_EN
          else if (tmo_hit) begin
            state_q <= ERR;
          end else begin
            tmo_q   <= tmo_q + 16'd1;
          end
`endif
        end
        ERR: begin
          last_q  <= gidx_q;
          gnt_q   <= '0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nmi_arbmux.sv
// Directed bench for nmi_arbmux (4 masters, 3 slaves); slave i answers with
// rdata {4'hA, i, 8'h00, addr[15:0]} after swait[i] wait cycles.
module tb_nmi_arbmux;
  import nmi_pkg::*;

  localparam int unsigned NM = 4;
  localparam int unsigned NS = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NM-1:0] gnt;
  logic          err;
  int            ncmp = 0;
  int            nfail = 0;
  logic [15:0]   swait [NS];
  logic [15:0]   scnt  [NS];

  nmi_arbmux_if #(.NMSTR(NM), .NSLV(NS)) bus ();

  nmi_arbmux #(
    .NMSTR(NM),
    .NSLV (NS)
`ifdef NMI_ARBMUX_TIMEOUT_EN
    , .TIMEOUT_CYC(8)
`endif
  ) dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .bus    (bus),
    .gnt_o  (gnt),
    .err_o  (err)
  );

  always #5 clk = ~clk;

  // Slave models: count wait cycles while selected and not yet ready.
  always @(posedge clk) begin
    for (int i = 0; i < NS; i++)
      scnt[i] <= (bus.s_valid_o[i] && !bus.s_ready_i[i]) ? scnt[i] + 16'd1 : 16'd0;
  end

  always_comb begin
    for (int i = 0; i < NS; i++) begin
      bus.s_ready_i[i] = bus.s_valid_o[i] && (scnt[i] >= swait[i]);
      bus.s_rdata_i[i] = {4'hA, 4'(i), 8'h00, bus.s_addr_o[15:0]};
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] m, input logic [31:0] a, input logic [31:0] d);
    bus.m_valid_i[m] = 1'b1;
    bus.m_addr_i[m]  = a;
    bus.m_wdata_i[m] = d;
    bus.m_wstrb_i[m] = 4'hF;
  endtask

  // Returns the number of falling edges until a masked ready appears, -1 on expiry.
  task automatic wait_rdy(input logic [NM-1:0] mask, input int budget, output int n);
    n = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if ((bus.m_ready_o & mask) != '0) begin
        n = k + 1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    int          n;
    logic [3:0]  d_exp [5];
    d_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    bus.m_valid_i = '0;
    bus.m_addr_i  = '0;
    bus.m_wdata_i = '0;
    bus.m_wstrb_i = '0;
    for (int i = 0; i < NS; i++) swait[i] = 16'd0;

    // Reset values
    #3;
    check("rst_svalid", bus.s_valid_o, 3'b000);
    check("rst_mready", bus.m_ready_o, 4'b0000);
    check("rst_mrdata", bus.m_rdata_o, 128'h0);
    check("rst_gnt", gnt, 4'b0000);
    check("rst_err", err, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // A: m0 and m1 together -> m0 first, m1 one idle cycle later
    drive(2'd0, 32'h1000_0000, 32'h1111_0000);
    drive(2'd1, 32'h1000_0000, 32'h2222_0001);
    wait_rdy(4'b0001, 20, n);
    check("A_m0_lat", 128'(n + 1), 128'd2);
    check("A_m0_gnt", gnt, 4'b0001);
    check("A_m0_mready", bus.m_ready_o, 4'b0001);
    check("A_m0_rdata", bus.m_rdata_o, {96'h0, 32'hA200_0000});
    check("A_m0_svalid", bus.s_valid_o, 3'b100);
    check("A_m0_wdata", bus.s_wdata_o, 32'h1111_0000);
    bus.m_valid_i[0] = 1'b0;
    @(negedge clk);
    check("A_gap_gnt", gnt, 4'b0000);
    wait_rdy(4'b0010, 20, n);
    check("A_m1_n", 128'(n), 128'd1);
    check("A_m1_gnt", gnt, 4'b0010);
    check("A_m1_mready", bus.m_ready_o, 4'b0010);
    check("A_m1_wdata", bus.s_wdata_o, 32'h2222_0001);
    bus.m_valid_i[1] = 1'b0;
    @(negedge clk);

    // B: m1 to slave 1 with 3 wait cycles; m0 arrives mid-transaction
    swait[1] = 16'd3;
    drive(2'd1, 32'h3000_0004, 32'h3333_0002);
    @(negedge clk);
    check("B_busy_gnt", gnt, 4'b0010);
    check("B_busy_svalid", bus.s_valid_o, 3'b010);
    check("B_busy_addr", bus.s_addr_o, 32'h3000_0004);
    check("B_busy_mready", bus.m_ready_o, 4'b0000);
    drive(2'd0, 32'h1000_0000, 32'h4444_0003);
    wait_rdy(4'b0010, 20, n);
    check("B_m1_lat", 128'(n + 2), 128'd5);
    check("B_m1_gnt", gnt, 4'b0010);
    check("B_m1_mready", bus.m_ready_o, 4'b0010);
    check("B_m1_rdata", bus.m_rdata_o, {32'h0, 32'h0, 32'hA100_0004, 32'h0});
    bus.m_valid_i[1] = 1'b0;
    swait[1] = 16'd0;
    wait_rdy(4'b0001, 20, n);
    check("B_m0_n", 128'(n), 128'd2);
    check("B_m0_gnt", gnt, 4'b0001);
    bus.m_valid_i[0] = 1'b0;
    @(negedge clk);

    // C: decode miss -> error response
    drive(2'd0, 32'h7700_0000, 32'h5555_0004);
    @(negedge clk);
    check("C_err", err, 1'b1);
    check("C_mready", bus.m_ready_o, 4'b0001);
    check("C_rdata", bus.m_rdata_o, {96'h0, 32'hDEAD_BEEF});
    check("C_svalid", bus.s_valid_o, 3'b000);
    check("C_gnt", gnt, 4'b0001);
    bus.m_valid_i[0] = 1'b0;
    @(negedge clk);
    check("C_err_end", err, 1'b0);
    check("C_mready_end", bus.m_ready_o, 4'b0000);
    check("C_svalid_end", bus.s_valid_o, 3'b000);

    // E: reset in the middle of a stalled transaction
    swait[2] = 16'hFFFF;
    drive(2'd2, 32'h1000_0000, 32'h6666_0005);
    @(negedge clk);
    check("E_busy_gnt", gnt, 4'b0100);
    check("E_busy_svalid", bus.s_valid_o, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check("E_rst_svalid", bus.s_valid_o, 3'b000);
    check("E_rst_mready", bus.m_ready_o, 4'b0000);
    check("E_rst_mrdata", bus.m_rdata_o, 128'h0);
    check("E_rst_gnt", gnt, 4'b0000);
    check("E_rst_err", err, 1'b0);
    bus.m_valid_i = '0;
    swait[2] = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;

    // D: all masters request continuously -> 0,1,2,3,0
    for (int m = 0; m < NM; m++) drive(2'(m), 32'h1000_0000, 32'(m));
    for (int k = 0; k < 5; k++) begin
      wait_rdy(4'b1111, 20, n);
      check($sformatf("D_n%0d", k), 128'(n), (k == 0) ? 128'd1 : 128'd2);
      check($sformatf("D_gnt%0d", k), gnt, d_exp[k]);
      check($sformatf("D_mready%0d", k), bus.m_ready_o, d_exp[k]);
    end
    bus.m_valid_i = '0;
    @(negedge clk);

`ifdef NMI_ARBMUX_TIMEOUT_EN
    // F: slave never answers -> timeout after 8 BUSY cycles
    begin
      int sv;
      sv = 0;
      swait[2] = 16'hFFFF;
      drive(2'd3, 32'h1000_0000, 32'h7777_0006);
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (bus.m_ready_o[3]) break;
        if (bus.s_valid_o[2]) sv++;
      end
      check("F_busy_cycles", 128'(sv), 128'd8);
      check("F_err", err, 1'b1);
      check("F_mready", bus.m_ready_o, 4'b1000);
      check("F_rdata", bus.m_rdata_o, {32'hDEAD_BEEF, 96'h0});
      check("F_svalid", bus.s_valid_o, 3'b000);
      bus.m_valid_i = '0;
      swait[2] = 16'd0;
      @(negedge clk);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/nmi_arbmux.md
NMI_ARBMUX -- requirements
Module: nmi_arbmux

Interface
REQ-001 SHALL have parameter NMSTR, default 2, giving the number of NMI masters (2..8).
REQ-002 SHALL have parameter NSLV, default 3, giving the number of NMI slaves (1..8).
REQ-003 SHALL have parameter SLV_BASE, default {8'h10,8'h30,8'h03}, giving the per-slave match value for addr[31:24].
REQ-004 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF, giving the read data returned on a decode miss or timeout.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_n_i, input, 1 bit: the reset, asynchronous and active-low.
REQ-007 SHALL have master ports m_valid_i [NMSTR], m_addr_i [NMSTR][32], m_wdata_i [NMSTR][32] and m_wstrb_i [NMSTR][4] as inputs carrying the NMI requests.
REQ-008 SHALL have master ports m_ready_o [NMSTR] and m_rdata_o [NMSTR][32] as outputs carrying the NMI responses.
REQ-009 SHALL have slave ports s_valid_o [NSLV], s_addr_o [32], s_wdata_o [32] and s_wstrb_o [4] as outputs; addr, wdata and wstrb are shared by all slaves.
REQ-010 SHALL have slave ports s_ready_i [NSLV] and s_rdata_i [NSLV][32] as inputs.
REQ-011 SHALL have port gnt_o, output, NMSTR bits: the one-hot current grant.
REQ-012 SHALL have port err_o, output, 1 bit: a one-cycle pulse on a decode miss or timeout.

Function
REQ-013 SHALL implement the FSM states IDLE, BUSY and ERR.
REQ-014 SHALL, in IDLE with any m_valid_i set, select the grant round-robin starting at the index after last_q (wrapping NMSTR-1->0), register it into gnt_q and enter BUSY or ERR on the next edge.
REQ-015 SHALL make the transition target BUSY when exactly one SLV_BASE equals the granted addr[31:24], and ERR otherwise, recording the matched slave index in sel_q.
REQ-016 SHALL, in BUSY, drive s_valid_o[sel_q]=1 with the granted master's addr, wdata and wstrb, and hold all other s_valid_o at 0.
REQ-017 SHALL, in BUSY, forward s_ready_i[sel_q] and s_rdata_i[sel_q] combinationally to the granted master only; all non-granted m_ready_o and m_rdata_o SHALL be 0.
REQ-018 SHALL, on s_ready_i[sel_q]=1 in BUSY, set last_q to the granted index, clear gnt_q and return to IDLE; the earliest re-arbitration is the following cycle.
REQ-019 SHALL, in ERR, drive m_ready_o=1 and m_rdata_o=ERR_RDATA for one cycle to the granted master, pulse err_o, and return to IDLE.
REQ-020 SHALL give a minimum request-to-ready latency of 2 cycles (arbitration plus a zero-wait slave).
REQ-021 SHALL keep gnt_q stable while BUSY, ignoring newly asserted m_valid_i from any other master.
REQ-022 SHALL pass a single requesting master without starvation and serve requests in strict rotation when all masters request continuously.
REQ-023 SHALL treat dropping m_valid_i before m_ready_o as a protocol violation: the transaction continues and the slave is not aborted.

Reset
REQ-024 SHALL, on rst_n_i=0, asynchronously set state=IDLE, gnt_q=0, last_q=NMSTR-1 and sel_q=0, so that master 0 wins the first arbitration.
REQ-025 SHALL, while in reset, hold all s_valid_o, m_ready_o, m_rdata_o, gnt_o and err_o at 0.
REQ-026 SHALL, on a reset asserted mid-BUSY, drop the in-flight transaction with no response issued.

Configuration
REQ-027 SHALL, when NMI_ARBMUX_TIMEOUT_EN is defined, run a 16-bit counter that is cleared on BUSY entry and increments each BUSY cycle; on reaching parameter TIMEOUT_CYC (default 1024), it SHALL deassert s_valid_o and enter ERR.
REQ-028 SHALL, when NMI_ARBMUX_TIMEOUT_EN is undefined, contain no counter and remain in BUSY indefinitely until s_ready_i is asserted.

Structure
REQ-029 SHALL place the FSM state enum, the NMI field widths (ADDR_W=32, DATA_W=32, STRB_W=4) and the ERR_RDATA default in the shared package nmi_pkg.
REQ-030 SHALL implement the round-robin selection in the sub-module rr_arbiter (parameter N; inputs req and last; output one-hot gnt), which is combinational and reusable.

Verification
REQ-031 SHALL cover: m0 and m1 request 0x1000_0000 at the same time -> m0 granted, then m1 granted on the cycle after m0's ready, confirmed on gnt_o.
REQ-032 SHALL cover: m1 requests addr 0x3000_0004 with a slave holding 3 wait cycles -> m_ready_o[1] asserted 5 cycles after m_valid_i, with rdata matching the slave.
REQ-033 SHALL cover: m0 requests addr 0x7700_0000 -> ERR, m_rdata_o[0]=0xDEAD_BEEF, a one-cycle err_o pulse, and all s_valid_o remaining 0.
REQ-034 SHALL cover: NMSTR=4 with all masters requesting continuously -> grant order 0,1,2,3,0.
REQ-035 SHALL cover: NMI_ARBMUX_TIMEOUT_EN with TIMEOUT_CYC=8 and a slave that never responds -> err_o and ready with 0xDEAD_BEEF after 8 BUSY cycles.
REQ-036 SHALL cover: rst_n_i pulsed mid-BUSY -> all outputs 0 immediately, and master 0 wins the first post-reset arbitration.
